// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: one-hot scan consumer driving a 4-digit 7-segment display
// Double-buffered digit data (shadow -> active at frame start), anode dead-time
// after every select change, sticky invalid-select flag.
// Optional feature: define SEG7_LZB_EN for leading-zero blanking of digits 3..1.
// Ports:
//   iclk, ireset_n  clock (posedge), asynchronous active-low reset
//   ivsel[3:0]      one-hot digit select, bit k = digit k
//   ivdata[15:0]    digit nibbles, digit0 = [3:0] .. digit3 = [15:12]
//   ivdp[3:0]       decimal point per digit
//   iload           strobe: capture ivdata/ivdp into the shadow buffer
//   iclr_err        clears oerr
//   ovseg[6:0]      segments {g,f,e,d,c,b,a}
//   odp             decimal point of the displayed digit
//   ovan[3:0]       anode enables, bit k = digit k
//   oerr            sticky: select was not exactly one-hot
module seg7_scan_decoder #(
  parameter int DEAD_CYC    = 8,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic        iclk,
  input  logic        ireset_n,
  input  logic [3:0]  ivsel,
  input  logic [15:0] ivdata,
  input  logic [3:0]  ivdp,
  input  logic        iload,
  input  logic        iclr_err,
  output logic [6:0]  ovseg,
  output logic        odp,
  output logic [3:0]  ovan,
  output logic        oerr
);
  localparam int CW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DEAD_CYC);
  localparam logic [CW-1:0] CNT_LD = (DEAD_CYC == 0) ? '0 : CW'(DEAD_CYC - 1);
  typedef enum logic [1:0] {BLANK, SHOW, FAULT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0] sel_q, prev_q;
  logic arm;
  logic [19:0] shadow, active;
  logic sel_ok, prev_ok, chg, fault, frame_start;
  logic show, dp_bit, lzb;
  logic [3:0] nib, an_nx;
  logic [6:0] seg_on, seg_nx;
  logic dp_nx;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  assign sel_ok  = $onehot(sel_q);
  assign prev_ok = $onehot(prev_q);
  assign chg     = sel_q != prev_q;
  // arm masks the reset value of sel_q (0000) so it is not reported as a fault
  assign fault   = arm && !sel_ok;
  assign frame_start = (sel_q == 4'b0001) && (prev_q != 4'b0001);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      BLANK:
        if (fault) state_nx = FAULT;
        else if (chg && prev_ok) cnt_nx = CNT_LD;
        else if (cnt == '0) state_nx = sel_ok ? SHOW : BLANK;
        else cnt_nx = cnt - 1'b1;
      SHOW:
        if (fault) state_nx = FAULT;
        else if (chg && DEAD_CYC != 0) begin
          state_nx = BLANK;
          cnt_nx   = CNT_LD;
        end
      FAULT:
        if (sel_ok) begin
          state_nx = BLANK;
          cnt_nx   = CNT_LD;
        end
      default: state_nx = BLANK;
    endcase
  end

  // The display follows prev_q: on the edge where a new select arrives the old
  // digit is still shown, so the anode never switches without passing BLANK.
  assign show   = (state == SHOW) && prev_ok;
  assign nib    = prev_q[3] ? active[15:12] : prev_q[2] ? active[11:8] :
                  prev_q[1] ? active[7:4] : active[3:0];
  assign dp_bit = |(prev_q & active[19:16]);
`ifdef SEG7_LZB_EN
  assign lzb = (prev_q[3] && active[15:12] == 4'h0) ||
               (prev_q[2] && active[15:8] == 8'h00) ||
               (prev_q[1] && active[15:4] == 12'h000);
`else
  assign lzb = 1'b0;
`endif
  assign seg_on = (show && !lzb) ? hex7(nib) : 7'h00;
  assign an_nx  = (show ? prev_q : 4'h0) ^ {4{AN_ACT_LOW}};
  assign seg_nx = seg_on ^ {7{SEG_ACT_LOW}};
  assign dp_nx  = (show & dp_bit) ^ SEG_ACT_LOW;

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state  <= BLANK;
      cnt    <= CNT_INIT;
      sel_q  <= 4'h0;
      prev_q <= 4'h0;
      arm    <= 1'b0;
      shadow <= '0;
      active <= '0;
      oerr   <= 1'b0;
      ovan   <= {4{AN_ACT_LOW}};
      ovseg  <= {7{SEG_ACT_LOW}};
      odp    <= SEG_ACT_LOW;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      sel_q  <= ivsel;
      prev_q <= sel_q;
      arm    <= 1'b1;
      if (iload) shadow <= {ivdp, ivdata};
      if (frame_start) active <= shadow;
      oerr   <= fault | (oerr & ~iclr_err);
      ovan   <= an_nx;
      ovseg  <= seg_nx;
      odp    <= dp_nx;
    end
  end
endmodule
